// File: rtl/seq_ser_pkg.sv
// seq_ser_pkg: shared types and helpers for seq_bit_serializer.
// Optional feature macro: SER_PARITY_EN appends one even-parity bit to every word.
package seq_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Bits sent per word, including the optional parity bit.
    function automatic int unsigned frame_len(input int unsigned width);
`ifdef SER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

`ifdef SER_PARITY_EN
    // Even parity over a zero-extended word; extension bits do not change the result.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction
`endif

endpackage

// File: rtl/seq_word_fifo.sv
// seq_word_fifo: synchronous word FIFO with registered full/empty/count flags.
// Pushes when full and pops when empty are ignored.
module seq_word_fifo
    import seq_ser_pkg::*;
#(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Storage array; contents need no reset since flags gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and registered flags; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: buffers WIDTH-bit words and shifts them out one bit per accepted cycle.
// Optional feature macro: SER_PARITY_EN sends an even-parity bit after each word's data bits.
module seq_bit_serializer
    import seq_ser_pkg::*;
#(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             bit_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned FRAME_LEN = frame_len(WIDTH);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    ser_state_e           state;
    ser_state_e           state_next;
    logic [FRAME_LEN-1:0] shift_reg;
    logic [FRAME_LEN-1:0] shift_next;
    logic [FRAME_LEN-1:0] load_frame;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic                 bit_out_next;
    logic                 bit_valid_next;
    logic                 frame_start_next;
    logic                 load;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [OCC_W-1:0]     fifo_count;
    logic [WIDTH-1:0]     fifo_data;

    assign s_ready = !fifo_full;
    assign busy    = (state == SHIFT) || (fifo_count != '0);

    seq_word_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid && s_ready),
        .pop     (load),
        .wr_data (s_data),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Arrange the head word so the first bit to send sits in the frame MSB.
    always_comb begin
        load_frame = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            load_frame[FRAME_LEN-1-i] = MSB_FIRST ? fifo_data[WIDTH-1-i] : fifo_data[i];
        end
`ifdef SER_PARITY_EN
        load_frame[0] = even_parity(64'(fifo_data));
`endif
    end

    // Next-state and output decode; a load pops the FIFO and presents the first bit.
    always_comb begin
        state_next       = state;
        shift_next       = shift_reg;
        cnt_next         = bit_cnt;
        bit_out_next     = bit_out;
        bit_valid_next   = bit_valid;
        frame_start_next = frame_start;
        load             = 1'b0;

        case (state)
            IDLE: begin
                load = !fifo_empty;
            end
            SHIFT: begin
                if (bit_ready) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_next       = IDLE;
                            cnt_next         = '0;
                            bit_out_next     = IDLE_BIT;
                            bit_valid_next   = 1'b0;
                            frame_start_next = 1'b0;
                        end
                    end else begin
                        shift_next       = shift_reg << 1;
                        cnt_next         = bit_cnt + CNT_W'(1);
                        bit_out_next     = shift_reg[FRAME_LEN-2];
                        frame_start_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            state_next       = SHIFT;
            shift_next       = load_frame;
            cnt_next         = '0;
            bit_out_next     = load_frame[FRAME_LEN-1];
            bit_valid_next   = 1'b1;
            frame_start_next = 1'b1;
        end
    end

    // State, shift register, bit counter and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            bit_out     <= IDLE_BIT;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            shift_reg   <= shift_next;
            bit_cnt     <= cnt_next;
            bit_out     <= bit_out_next;
            bit_valid   <= bit_valid_next;
            frame_start <= frame_start_next;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed self-checking bench for seq_bit_serializer
// (WIDTH=5, FIFO_DEPTH=2, MSB_FIRST=1, IDLE_BIT=0). Honours SER_PARITY_EN.
module tb_seq_bit_serializer;
    import seq_ser_pkg::*;

    localparam int unsigned WIDTH = 5;
    localparam int          FL    = int'(frame_len(WIDTH));

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             s_valid   = 1'b0;
    logic [WIDTH-1:0] s_data    = '0;
    logic             bit_ready = 1'b1;
    logic             s_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             frame_start;
    logic             busy;

    int checks  = 0;
    int errors  = 0;
    int waited  = 0;
    int det_cnt = 0;
    logic [3:0] hist = '0;

    always #5 clk = ~clk;

    seq_bit_serializer #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (2),
        .MSB_FIRST  (1'b1),
        .IDLE_BIT   (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .bit_ready   (bit_ready),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    // Downstream 10101 detector on accepted bits (overlapping matches count).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    <= '0;
            det_cnt <= 0;
        end else if (bit_valid && bit_ready) begin
            if ({hist, bit_out} == 5'b10101) det_cnt <= det_cnt + 1;
            hist <= {hist[2:0], bit_out};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serial image of one word as the consumer should see it.
    function automatic logic [31:0] frame_bits(input logic [WIDTH-1:0] d);
`ifdef SER_PARITY_EN
        return {26'b0, d, ^d};
`else
        return {27'b0, d};
`endif
    endfunction

    // Marks the first bit of each of nw back-to-back frames.
    function automatic logic [31:0] start_mask(input int nw);
        logic [31:0] m = '0;
        for (int w = 0; w < nw; w++) m[(nw - w) * FL - 1] = 1'b1;
        return m;
    endfunction

    // Called on a negedge: offers d, holds it until accepted, returns on the following negedge.
    task automatic push(input logic [WIDTH-1:0] d);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("push.ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Expects n contiguous bits (MSB of bits[n-1:0] first); toggle holds each bit one extra cycle.
    task automatic expect_stream(input string tag, input logic [31:0] bits, input int n,
                                 input bit toggle, output int wcnt);
        logic [31:0] fs;
        fs   = start_mask(n / FL);
        wcnt = 0;
        if (!toggle) bit_ready = 1'b1;
        while (!bit_valid && wcnt < 20) begin
            @(negedge clk);
            wcnt++;
        end
        check({tag, ".start"}, 32'(bit_valid), 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < (toggle ? 2 : 1); r++) begin
                check($sformatf("%s.bit%0d.%0d", tag, i, r),
                      32'({bit_valid, bit_out, frame_start}),
                      32'({1'b1, bits[n-1-i], fs[n-1-i]}));
                if (toggle) bit_ready = (r == 1);
                @(negedge clk);
            end
        end
        bit_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stream;

        // 1: reset then idle
        @(negedge clk);
        check("t1.in_reset", 32'({bit_valid, bit_out, s_ready, busy}), 32'b0010);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("t1.idle%0d", k), 32'({bit_valid, bit_out, s_ready, busy}), 32'b0010);
        end

        // 2: single word, one-cycle latency, detector fires once
        push(5'b10101);
        check("t2.not_yet", 32'({bit_valid, busy}), 32'b01);
        expect_stream("t2", frame_bits(5'b10101), FL, 1'b0, waited);
        check("t2.latency", 32'(waited), 32'd1);
        check("t2.end", 32'({bit_valid, bit_out, frame_start, busy}), 32'b0000);
        check("t2.detect", 32'(det_cnt), 32'd1);

        // 3: back-to-back words, no gap, s_ready stays high
        push(5'b11001);
        check("t3.ready_mid", 32'(s_ready), 32'd1);
        push(5'b00111);
        check("t3.ready_after", 32'(s_ready), 32'd1);
        stream = (frame_bits(5'b11001) << FL) | frame_bits(5'b00111);
        expect_stream("t3", stream, 2 * FL, 1'b0, waited);
        check("t3.latency", 32'(waited), 32'd0);
        check("t3.end", 32'({bit_valid, busy}), 32'b00);

        // 4: stalled consumer fills buffer; a fourth word is held off while full
        bit_ready = 1'b0;
        push(5'b10011);
        push(5'b01101);
        push(5'b11100);
        check("t4.full", 32'(s_ready), 32'd0);
        stream = (((((frame_bits(5'b10011) << FL) | frame_bits(5'b01101)) << FL)
                  | frame_bits(5'b11100)) << FL) | frame_bits(5'b00110);
        fork
            push(5'b00110);
            begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("t4.frozen%0d", k),
                          32'({bit_valid, bit_out, frame_start, s_ready}), 32'b1110);
                    @(negedge clk);
                end
                expect_stream("t4", stream, 4 * FL, 1'b0, waited);
            end
        join
        check("t4.end", 32'({bit_valid, busy, s_ready}), 32'b001);

        // 5: bit_ready toggling holds every bit two cycles
        bit_ready = 1'b0;
        push(5'b10110);
        expect_stream("t5", frame_bits(5'b10110), FL, 1'b1, waited);
        check("t5.end", 32'({bit_valid, busy}), 32'b00);

        // 6: reset on third bit discards current and buffered words
        push(5'b10011);
        push(5'b01101);
        check("t6.bit0", 32'({bit_valid, bit_out, frame_start}), 32'b111);
        @(negedge clk);
        @(negedge clk);
        check("t6.bit2", 32'({bit_valid, bit_out, frame_start, busy}), 32'b1001);
        rst = 1'b1;
        @(negedge clk);
        check("t6.reset", 32'({bit_valid, bit_out, frame_start, s_ready, busy}), 32'b00010);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("t6.quiet%0d", k), 32'({bit_valid, bit_out, busy}), 32'b000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
